// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between pc_sequencer (slave side) and the CPU/memory/counter side (master).
interface pc_sequencer_if;
  logic [31:0] i_PC;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic        i_exec_done;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_trap;
  logic [31:0] i_trap_vector;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        o_load_PC;
  logic        o_jump_DV;
  logic [31:0] o_jump_address;
  logic        o_fetch_fault;

  modport slave (
    input  i_PC, i_mem_ready, i_mem_rdata, i_exec_done,
    input  i_branch_taken, i_branch_target, i_trap, i_trap_vector,
    output o_mem_req, o_mem_addr, o_instr, o_instr_valid,
    output o_load_PC, o_jump_DV, o_jump_address, o_fetch_fault
  );

  modport master (
    output i_PC, i_mem_ready, i_mem_rdata, i_exec_done,
    output i_branch_taken, i_branch_target, i_trap, i_trap_vector,
    input  o_mem_req, o_mem_addr, o_instr, o_instr_valid,
    input  o_load_PC, o_jump_DV, o_jump_address, o_fetch_fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: reset-vector load, fetch/wait, execute wait and PC update with trap > branch > +4.
// Optional fetch-wait timeout enabled by macro FETCH_TIMEOUT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic           i_clk,
  input logic           i_rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t state_r;

  assign bus.o_mem_addr = bus.i_PC;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;
`else
  assign bus.o_fetch_fault = 1'b0;
`endif

  // Outputs are registered on entry to a state, so each strobe lines up with the state it belongs to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r            <= S_RESET;
      bus.o_mem_req      <= 1'b0;
      bus.o_instr        <= 32'h0000_0000;
      bus.o_instr_valid  <= 1'b0;
      bus.o_load_PC      <= 1'b0;
      bus.o_jump_DV      <= 1'b0;
      bus.o_jump_address <= 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
      bus.o_fetch_fault  <= 1'b0;
      wait_cnt_r         <= '0;
`endif
    end else begin
      case (state_r)
        // First cycle out of reset raises the strobe; the second hands over to fetch.
        S_RESET: begin
          if (!bus.o_load_PC) begin
            bus.o_load_PC      <= 1'b1;
            bus.o_jump_DV      <= 1'b1;
            bus.o_jump_address <= RESET_VECTOR;
          end else begin
            bus.o_load_PC      <= 1'b0;
            bus.o_jump_DV      <= 1'b0;
            bus.o_jump_address <= 32'h0000_0000;
            bus.o_mem_req      <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_r         <= '0;
`endif
            state_r            <= S_FETCH;
          end
        end
        S_FETCH, S_WAIT: begin
          if (bus.i_mem_ready) begin
            bus.o_instr       <= bus.i_mem_rdata;
            bus.o_instr_valid <= 1'b1;
            bus.o_mem_req     <= 1'b0;
            state_r           <= S_EXEC;
          end else if (state_r == S_FETCH) begin
            state_r <= S_WAIT;
          end else begin
`ifdef FETCH_TIMEOUT_EN
            // Ready in the expiry cycle takes the branch above, so a late fetch still wins.
            if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              bus.o_fetch_fault  <= 1'b1;
              bus.o_mem_req      <= 1'b0;
              bus.o_load_PC      <= 1'b1;
              bus.o_jump_DV      <= 1'b1;
              bus.o_jump_address <= bus.i_trap_vector;
              state_r            <= S_UPDATE;
            end else begin
              wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
`else
            state_r <= S_WAIT;
`endif
          end
        end
        S_EXEC: begin
          bus.o_instr_valid <= 1'b0;
          if (bus.i_exec_done) begin
            bus.o_load_PC <= 1'b1;
            if (bus.i_trap) begin
              bus.o_jump_DV      <= 1'b1;
              bus.o_jump_address <= bus.i_trap_vector;
            end else if (bus.i_branch_taken) begin
              bus.o_jump_DV      <= 1'b1;
              bus.o_jump_address <= bus.i_branch_target;
            end else begin
              bus.o_jump_DV      <= 1'b0;
              bus.o_jump_address <= 32'h0000_0000;
            end
            state_r <= S_UPDATE;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_UPDATE: begin
          bus.o_load_PC      <= 1'b0;
          bus.o_jump_DV      <= 1'b0;
          bus.o_jump_address <= 32'h0000_0000;
          bus.o_mem_req      <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_r         <= '0;
`endif
          state_r            <= S_FETCH;
        end
        default: begin
          state_r            <= S_RESET;
          bus.o_mem_req      <= 1'b0;
          bus.o_instr_valid  <= 1'b0;
          bus.o_load_PC      <= 1'b0;
          bus.o_jump_DV      <= 1'b0;
          bus.o_jump_address <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table for full instructions plus hand-written
// sequences for reset, fetch wait, mid-fetch reset and (with FETCH_TIMEOUT_EN) the fetch timeout.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  logic [31:0] pc_r;
  int checks;
  int errors;

  pc_sequencer_if bus ();

`ifdef FETCH_TIMEOUT_EN
  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));
`else
  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: loads jump address or advances by 4 on the strobe.
  initial pc_r = 32'h1234_5670;
  always @(posedge clk) begin
    if (bus.o_load_PC) pc_r <= bus.o_jump_DV ? bus.o_jump_address : pc_r + 32'd4;
  end
  assign bus.i_PC = pc_r;

  typedef struct {
    logic [31:0] rdata;
    logic        branch;
    logic [31:0] target;
    logic        trap;
    logic [31:0] vector;
    logic        exp_jdv;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.o_mem_req), 32'd0);
    chk({tag, "_instr"}, bus.o_instr, 32'd0);
    chk({tag, "_instr_valid"}, 32'(bus.o_instr_valid), 32'd0);
    chk({tag, "_load_pc"}, 32'(bus.o_load_PC), 32'd0);
    chk({tag, "_jump_dv"}, 32'(bus.o_jump_DV), 32'd0);
    chk({tag, "_jump_addr"}, bus.o_jump_address, 32'd0);
    chk({tag, "_fetch_fault"}, 32'(bus.o_fetch_fault), 32'd0);
  endtask

  task automatic chk_reset_release(input string tag);
    rst = 1'b0;
    tick();
    chk({tag, "_rv_load"}, 32'(bus.o_load_PC), 32'd1);
    chk({tag, "_rv_jdv"}, 32'(bus.o_jump_DV), 32'd1);
    chk({tag, "_rv_addr"}, bus.o_jump_address, 32'h0000_0000);
    chk({tag, "_rv_req"}, 32'(bus.o_mem_req), 32'd0);
    tick();
    chk({tag, "_first_req"}, 32'(bus.o_mem_req), 32'd1);
    chk({tag, "_first_addr"}, bus.o_mem_addr, 32'h0000_0000);
    chk({tag, "_first_load"}, 32'(bus.o_load_PC), 32'd0);
  endtask

  // Completes an instruction from the EXEC cycle: sequential update, back to FETCH.
  task automatic finish_seq(input string tag, input logic [31:0] exp_next);
    bus.i_mem_ready = 1'b0;
    bus.i_exec_done = 1'b1;
    tick();
    chk({tag, "_load"}, 32'(bus.o_load_PC), 32'd1);
    chk({tag, "_jdv"}, 32'(bus.o_jump_DV), 32'd0);
    bus.i_exec_done = 1'b0;
    tick();
    chk({tag, "_next_addr"}, bus.o_mem_addr, exp_next);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{32'h0050_0093, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0000_0463, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 32'h0000_0100};
    vecs[2] = '{32'h0000_0073, 1'b1, 32'h0000_0200, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{32'h0010_0113, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h8000_0004};
    vecs[4] = '{32'h0000_006f, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[5] = '{32'h0000_0013, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'h0020_0193, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[7] = '{32'h0030_0213, 1'b0, 32'h0000_0555, 1'b0, 32'h0000_0666, 1'b0, 32'h0000_0000, 32'h0000_0044};

    rst = 1'b1;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_rdata = 32'h0;
    bus.i_exec_done = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_branch_target = 32'h0;
    bus.i_trap = 1'b0;
    bus.i_trap_vector = 32'h0;
    tick();
    tick();
    chk_reset_outputs("reset");
    chk_reset_release("boot");

    for (int i = 0; i < 8; i++) begin
      bus.i_mem_ready = 1'b1;
      bus.i_mem_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("v%0d_instr", i), bus.o_instr, vecs[i].rdata);
      chk($sformatf("v%0d_valid", i), 32'(bus.o_instr_valid), 32'd1);
      chk($sformatf("v%0d_req_low", i), 32'(bus.o_mem_req), 32'd0);
      bus.i_mem_ready = 1'b0;
      bus.i_exec_done = 1'b1;
      bus.i_branch_taken = vecs[i].branch;
      bus.i_branch_target = vecs[i].target;
      bus.i_trap = vecs[i].trap;
      bus.i_trap_vector = vecs[i].vector;
      tick();
      chk($sformatf("v%0d_load", i), 32'(bus.o_load_PC), 32'd1);
      chk($sformatf("v%0d_jdv", i), 32'(bus.o_jump_DV), 32'(vecs[i].exp_jdv));
      chk($sformatf("v%0d_jaddr", i), bus.o_jump_address, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid_drop", i), 32'(bus.o_instr_valid), 32'd0);
      bus.i_exec_done = 1'b0;
      bus.i_branch_taken = 1'b0;
      bus.i_trap = 1'b0;
      bus.i_branch_target = 32'h0;
      bus.i_trap_vector = 32'h0;
      tick();
      chk($sformatf("v%0d_load_drop", i), 32'(bus.o_load_PC), 32'd0);
      chk($sformatf("v%0d_jdv_drop", i), 32'(bus.o_jump_DV), 32'd0);
      chk($sformatf("v%0d_next_req", i), 32'(bus.o_mem_req), 32'd1);
      chk($sformatf("v%0d_next_addr", i), bus.o_mem_addr, vecs[i].exp_next);
    end

    // Fetch wait of 5 cycles with a stray exec_done that must be ignored.
    bus.i_exec_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("wait%0d_req", k), 32'(bus.o_mem_req), 32'd1);
      chk($sformatf("wait%0d_load", k), 32'(bus.o_load_PC), 32'd0);
      chk($sformatf("wait%0d_valid", k), 32'(bus.o_instr_valid), 32'd0);
    end
    bus.i_exec_done = 1'b0;
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("wait_instr", bus.o_instr, 32'hDEAD_BEEF);
    chk("wait_valid", 32'(bus.o_instr_valid), 32'd1);
    bus.i_mem_rdata = 32'h1111_1111;
    tick();
    chk("exec_hold_valid", 32'(bus.o_instr_valid), 32'd0);
    chk("exec_hold_load", 32'(bus.o_load_PC), 32'd0);
    chk("exec_hold_instr", bus.o_instr, 32'hDEAD_BEEF);
    finish_seq("wait_done", 32'h0000_0048);

    // Reset asserted while waiting on memory.
    bus.i_mem_ready = 1'b0;
    tick();
    tick();
    chk("midfetch_req", 32'(bus.o_mem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    chk_reset_release("midrst");

`ifdef FETCH_TIMEOUT_EN
    // Ready arriving in the final wait cycle beats the timeout.
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("to_edge%0d_fault", k), 32'(bus.o_fetch_fault), 32'd0);
    end
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'h0000_0533;
    tick();
    chk("to_edge_valid", 32'(bus.o_instr_valid), 32'd1);
    chk("to_edge_fault", 32'(bus.o_fetch_fault), 32'd0);
    finish_seq("to_edge_done", 32'h0000_0004);

    bus.i_mem_ready = 1'b0;
    bus.i_trap_vector = 32'h0000_0800;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("to%0d_req", k), 32'(bus.o_mem_req), 32'd1);
      chk($sformatf("to%0d_fault", k), 32'(bus.o_fetch_fault), 32'd0);
    end
    tick();
    chk("to_fault", 32'(bus.o_fetch_fault), 32'd1);
    chk("to_load", 32'(bus.o_load_PC), 32'd1);
    chk("to_jdv", 32'(bus.o_jump_DV), 32'd1);
    chk("to_jaddr", bus.o_jump_address, 32'h0000_0800);
    chk("to_req_drop", 32'(bus.o_mem_req), 32'd0);
    tick();
    chk("to_refetch_addr", bus.o_mem_addr, 32'h0000_0800);
    chk("to_refetch_req", 32'(bus.o_mem_req), 32'd1);
    bus.i_mem_ready = 1'b1;
    tick();
    finish_seq("to_after", 32'h0000_0804);
    chk("to_sticky", 32'(bus.o_fetch_fault), 32'd1);
    rst = 1'b1;
    tick();
    chk("to_cleared", 32'(bus.o_fetch_fault), 32'd0);
    rst = 1'b0;
`else
    // Without the timeout the fetch waits well past 64 cycles with no fault.
    repeat (70) tick();
    chk("long_wait_req", 32'(bus.o_mem_req), 32'd1);
    chk("long_wait_fault", 32'(bus.o_fetch_fault), 32'd0);
    chk("long_wait_load", 32'(bus.o_load_PC), 32'd0);
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'h0000_0533;
    tick();
    chk("long_wait_valid", 32'(bus.o_instr_valid), 32'd1);
    finish_seq("long_wait_done", 32'h0000_0004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the CPU program counter register.
- Sequences each instruction through reset-vector load, fetch request/wait, execute wait and PC update.
- Drives the counter's load, jump-valid and jump-address inputs.
- Arbitrates redirect sources at each update: trap > taken branch > sequential +4.

Parameters:
RESET_VECTOR, 32'h00000000, address forced into the PC by the first update after reset
TIMEOUT_CYCLES, 64, fetch-wait cycle limit before a fetch fault (used only with the optional feature)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_PC  input  32  current PC from the program counter
i_mem_ready  input  1  instruction memory data valid this cycle
i_mem_rdata  input  32  instruction word from memory
i_exec_done  input  1  execute stage finished the current instruction
i_branch_taken  input  1  branch/jump resolved taken; sampled with i_exec_done
i_branch_target  input  32  branch destination; sampled with i_exec_done
i_trap  input  1  exception request; sampled with i_exec_done
i_trap_vector  input  32  trap handler address
o_mem_req  output  1  fetch request to instruction memory
o_mem_addr  output  32  fetch address, equal to i_PC
o_instr  output  32  latched instruction
o_instr_valid  output  1  one-cycle pulse when o_instr is updated
o_load_PC  output  1  PC update strobe
o_jump_DV  output  1  selects o_jump_address instead of PC+4
o_jump_address  output  32  redirect address
o_fetch_fault  output  1  sticky fetch-timeout flag (optional feature)

Behaviour:
- Clocking and reset:
  - Single clock, i_clk.
  - i_rst is synchronous, active-high and overrides everything, including a fetch in progress.
- Reset values:
  - state = S_RESET.
  - o_mem_req = 0, o_instr = 0, o_instr_valid = 0, o_load_PC = 0, o_jump_DV = 0, o_jump_address = 0, o_fetch_fault = 0.
- States and transitions:
  - S_RESET: for one cycle drive o_load_PC = 1, o_jump_DV = 1, o_jump_address = RESET_VECTOR. Next state S_FETCH.
  - S_FETCH: o_mem_req = 1, o_mem_addr = i_PC.
    - If i_mem_ready is also 1 in this cycle: latch o_instr, pulse o_instr_valid, go to S_EXEC.
    - Otherwise go to S_WAIT.
  - S_WAIT: hold o_mem_req = 1. When i_mem_ready = 1, latch i_mem_rdata into o_instr, pulse o_instr_valid for one cycle, go to S_EXEC.
  - S_EXEC: o_mem_req = 0. Wait for i_exec_done. When it is seen, register the redirect decision and go to S_UPDATE.
    - i_trap = 1: jump = 1, address = i_trap_vector.
    - else i_branch_taken = 1: jump = 1, address = i_branch_target.
    - else: jump = 0, address = 0.
  - S_UPDATE: for exactly one cycle drive o_load_PC = 1 with the registered o_jump_DV / o_jump_address. Next state S_FETCH.
- Strobe and sampling rules:
  - o_load_PC is high only in S_RESET and S_UPDATE, never two consecutive cycles.
  - o_jump_DV and o_jump_address are meaningful only while o_load_PC = 1; they are 0 otherwise.
  - Redirect inputs are ignored outside the S_EXEC cycle in which i_exec_done = 1.
  - i_trap and i_branch_taken both high: trap wins.
  - i_exec_done or i_mem_ready in a state that does not expect it: ignored.
- Timing:
  - PC changes on the clock edge that ends S_UPDATE.
  - Next fetch is issued with the new PC in the following cycle.
  - Minimum instruction period: 3 cycles (S_FETCH with ready, S_EXEC with done, S_UPDATE).
- Addresses:
  - PC+4 wraps modulo 2^32 inside the counter.
  - Targets are passed through unmodified; no alignment check.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_FETCH and increments each cycle in S_WAIT.
  - If it reaches TIMEOUT_CYCLES with no i_mem_ready: set o_fetch_fault (sticky until i_rst), drop o_mem_req, go to S_UPDATE with jump = 1 and address = i_trap_vector.
  - i_mem_ready arriving in the same cycle as the timeout wins (normal fetch).
- Not defined:
  - No counter; S_WAIT waits indefinitely.
  - o_fetch_fault is tied to 0.

Test Plan:
- Reset: assert i_rst for 2 cycles, then release -> first cycle after release o_load_PC = 1, o_jump_DV = 1, o_jump_address = 0x00000000; next cycle o_mem_req = 1, o_mem_addr = 0.
- Sequential flow: i_mem_ready = 1 with data 0x00500093, i_exec_done = 1 with no branch and no trap -> o_instr = 0x00500093, o_instr_valid pulses once, o_load_PC = 1 with o_jump_DV = 0; next fetch address = 0x4.
- Branch: i_exec_done with i_branch_taken = 1 and target 0x100 -> o_jump_DV = 1, o_jump_address = 0x100; next o_mem_addr = 0x100.
- Trap priority: i_trap = 1 and i_branch_taken = 1 together, vector 0x80000000 and target 0x200 -> o_jump_address = 0x80000000.
- Wait and reset mid-fetch: i_mem_ready held low 5 cycles -> o_mem_req stays 1 and no o_load_PC; then assert i_rst in S_WAIT -> next cycle all outputs at reset values and state S_RESET.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and i_mem_ready held low -> after 8 wait cycles o_fetch_fault = 1 and o_load_PC = 1 with o_jump_address = i_trap_vector; o_fetch_fault stays 1 until i_rst.
